// File: rtl/lut_sweep_eval.sv
// Run-time programmable N_IN-input truth-table evaluator with serial table load,
// valid/ready vector evaluation and a full-table sweep stream.
module lut_sweep_eval #(
    parameter int                  N_IN    = 3,
    parameter logic [2**N_IN-1:0]  INIT_TT = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    output logic            cfg_ready,
    output logic            cfg_done,
    input  logic            in_valid,
    input  logic [N_IN-1:0] in_data,
    output logic            in_ready,
    input  logic            sweep_start,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_data,
    output logic [N_IN-1:0] out_idx,
    output logic            out_last
);
    localparam int              DEPTH    = 2**N_IN;
    localparam logic [N_IN:0]   LAST_POS = (N_IN+1)'(DEPTH-1);

    typedef enum logic [1:0] {IDLE, LOAD, SWEEP} state_t;

    state_t           state_reg;
    logic [DEPTH-1:0] tt_reg;
    logic [DEPTH-1:0] shadow_reg;
    logic [DEPTH-1:0] shadow_next;
    logic [N_IN:0]    cnt_reg;
    logic [N_IN:0]    idx_reg;
    logic             slot_free;
    logic             is_idle;

    assign is_idle     = (state_reg == IDLE);
    assign slot_free   = !out_valid || out_ready;
    assign in_ready    = is_idle && !sweep_start && !cfg_valid && slot_free;
    assign cfg_ready   = (is_idle && !sweep_start) || (state_reg == LOAD);
    assign busy        = !is_idle;
    assign shadow_next = {shadow_reg[DEPTH-2:0], cfg_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            tt_reg     <= INIT_TT;
            shadow_reg <= '0;
            cnt_reg    <= '0;
            idx_reg    <= '0;
            out_valid  <= 1'b0;
            out_data   <= 1'b0;
            out_idx    <= '0;
            out_last   <= 1'b0;
            cfg_done   <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            // A consumed result drops valid unless a new one is loaded below.
            if (out_valid && out_ready)
                out_valid <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (sweep_start) begin
                        state_reg <= SWEEP;
                        idx_reg   <= '0;
                    end else if (cfg_valid) begin
                        shadow_reg <= shadow_next;
                        cnt_reg    <= (N_IN+1)'(1);
                        state_reg  <= LOAD;
                    end else if (in_valid && slot_free) begin
                        out_valid <= 1'b1;
                        out_data  <= tt_reg[in_data];
                        out_idx   <= in_data;
                        out_last  <= 1'b0;
                    end
                end
                LOAD: begin
                    if (cfg_valid) begin
                        shadow_reg <= shadow_next;
                        // Table swaps in one cycle so evaluations never see a partial load.
                        if (cnt_reg == LAST_POS) begin
                            tt_reg    <= shadow_next;
                            cfg_done  <= 1'b1;
                            cnt_reg   <= '0;
                            state_reg <= IDLE;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                SWEEP: begin
                    if (slot_free) begin
                        out_valid <= 1'b1;
                        out_data  <= tt_reg[idx_reg[N_IN-1:0]];
                        out_idx   <= idx_reg[N_IN-1:0];
                        out_last  <= (idx_reg == LAST_POS);
                        idx_reg   <= idx_reg + 1'b1;
                        if (idx_reg == LAST_POS)
                            state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lut_sweep_eval.sv
// Self-checking bench for lut_sweep_eval: N_IN=3 (INIT 0) and N_IN=4 (nonzero INIT).
module tb_lut_sweep_eval;
    localparam logic [15:0] INIT4 = 16'hA5C3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, cfg_valid, cfg_bit, in_valid, sweep_start, out_ready;
    logic [2:0] in_data;
    logic       cfg_ready, cfg_done, in_ready, busy, out_valid, out_data, out_last;
    logic [2:0] out_idx;

    logic       f_rst_n, f_cfg_valid, f_cfg_bit, f_in_valid, f_sweep_start, f_out_ready;
    logic [3:0] f_in_data;
    logic       f_cfg_ready, f_cfg_done, f_in_ready, f_busy, f_out_valid, f_out_data, f_out_last;
    logic [3:0] f_out_idx;

    lut_sweep_eval #(.N_IN(3), .INIT_TT(8'h00)) dut3 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
        .cfg_ready(cfg_ready), .cfg_done(cfg_done), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .sweep_start(sweep_start),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
    );

    lut_sweep_eval #(.N_IN(4), .INIT_TT(INIT4)) dut4 (
        .clk(clk), .rst_n(f_rst_n), .cfg_valid(f_cfg_valid), .cfg_bit(f_cfg_bit),
        .cfg_ready(f_cfg_ready), .cfg_done(f_cfg_done), .in_valid(f_in_valid),
        .in_data(f_in_data), .in_ready(f_in_ready), .sweep_start(f_sweep_start),
        .busy(f_busy), .out_valid(f_out_valid), .out_ready(f_out_ready),
        .out_data(f_out_data), .out_idx(f_out_idx), .out_last(f_out_last)
    );

    int checks   = 0;
    int failures = 0;
    logic [7:0]  tt3 = 8'h00;
    logic [15:0] tt4 = INIT4;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; f_rst_n = 1'b0;
        cfg_valid = 0; cfg_bit = 0; in_valid = 0; in_data = '0; sweep_start = 0; out_ready = 1;
        f_cfg_valid = 0; f_cfg_bit = 0; f_in_valid = 0; f_in_data = '0; f_sweep_start = 0; f_out_ready = 1;
        repeat (3) step();
        rst_n = 1'b1; f_rst_n = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (out_data !== 1'b0) begin failures++; $display("FAIL reset_out_data got=%b want=0", out_data); end
        checks++; if (out_idx !== 3'd0) begin failures++; $display("FAIL reset_out_idx got=%0d want=0", out_idx); end
        checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b want=0", out_last); end
        checks++; if (cfg_done !== 1'b0) begin failures++; $display("FAIL reset_cfg_done got=%b want=0", cfg_done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        in_valid = 1; in_data = 3'b101;
        step();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL reset_eval_valid got=%b want=1", out_valid); end
        checks++; if (out_data !== tt3[5]) begin failures++; $display("FAIL reset_eval_data got=%b want=%b", out_data, tt3[5]); end
        checks++; if (out_idx !== 3'd5) begin failures++; $display("FAIL reset_eval_idx got=%0d want=5", out_idx); end
        $display("eval idx=5 data=%b", out_data);
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_eval_drop got=%b want=0", out_valid); end
    endtask

    task automatic load3(input logic [7:0] val, input int gap_after, input int gap_len);
        for (int k = 7; k >= 0; k--) begin
            cfg_valid = 1; cfg_bit = val[k];
            #1;
            checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL load_cfg_ready got=%b want=1", cfg_ready); end
            step();
            cfg_valid = 0;
            checks++; if (cfg_done !== (k == 0)) begin failures++; $display("FAIL load_cfg_done bit=%0d got=%b want=%b", 8-k, cfg_done, (k == 0)); end
            checks++; if (busy !== (k != 0)) begin failures++; $display("FAIL load_busy bit=%0d got=%b want=%b", 8-k, busy, (k != 0)); end
            if (8 - k == gap_after) begin
                repeat (gap_len) begin
                    step();
                    checks++; if (cfg_done !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL load_gap got done=%b busy=%b want done=0 busy=1", cfg_done, busy); end
                end
            end
        end
        step();
        checks++; if (cfg_done !== 1'b0) begin failures++; $display("FAIL load_done_pulse got=%b want=0", cfg_done); end
        tt3 = val;
        $display("load tt=%h", val);
    endtask

    task automatic test_eval_b2b();
        logic [2:0] vecs [3] = '{3'd2, 3'd6, 3'd3};
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_data = vecs[i];
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_in_ready got=%b want=1", in_ready); end
            step();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b want=1", out_valid); end
            checks++; if (out_data !== tt3[vecs[i]]) begin failures++; $display("FAIL b2b_data idx=%0d got=%b want=%b", vecs[i], out_data, tt3[vecs[i]]); end
            checks++; if (out_idx !== vecs[i]) begin failures++; $display("FAIL b2b_idx got=%0d want=%0d", out_idx, vecs[i]); end
            checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL b2b_last got=%b want=0", out_last); end
            $display("eval idx=%0d data=%b", out_idx, out_data);
        end
        in_valid = 0;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drop got=%b want=0", out_valid); end
    endtask

    task automatic sweep3(input int stall_idx, input int stall_n, input bit all_req);
        int e = 0, cyc = 0, stalled = 0, held = 0;
        sweep_start = 1; out_ready = 1;
        if (all_req) begin cfg_valid = 1; cfg_bit = 1; in_valid = 1; in_data = 3'd1; end
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL sweep_in_ready got=%b want=0", in_ready); end
        checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL sweep_cfg_ready got=%b want=0", cfg_ready); end
        step();
        sweep_start = 0; cfg_valid = 0; in_valid = 0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL sweep_busy_start got=%b want=1", busy); end
        while (e < 8 && cyc < 100) begin
            step();
            cyc++;
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sweep_valid e=%0d got=%b want=1", e, out_valid); end
            checks++; if (out_idx !== 3'(e)) begin failures++; $display("FAIL sweep_idx got=%0d want=%0d", out_idx, e); end
            checks++; if (out_data !== tt3[e]) begin failures++; $display("FAIL sweep_data e=%0d got=%b want=%b", e, out_data, tt3[e]); end
            checks++; if (out_last !== (e == 7)) begin failures++; $display("FAIL sweep_last e=%0d got=%b want=%b", e, out_last, (e == 7)); end
            checks++; if (busy !== (e != 7)) begin failures++; $display("FAIL sweep_busy e=%0d got=%b want=%b", e, busy, (e != 7)); end
            if (out_valid && out_idx == 3'(stall_idx)) held++;
            $display("sweep idx=%0d data=%b last=%b", out_idx, out_data, out_last);
            if (e == stall_idx && stalled < stall_n) begin out_ready = 0; stalled++; end
            else out_ready = 1;
            if (out_ready) e++;
        end
        checks++; if (cyc >= 100) begin failures++; $display("FAIL sweep_timeout got=%0d want<100", cyc); end
        if (stall_n > 0) begin
            checks++; if (held !== stall_n + 1) begin failures++; $display("FAIL sweep_hold got=%0d want=%0d", held, stall_n + 1); end
        end
        step();
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL sweep_end got busy=%b valid=%b want 0 0", busy, out_valid); end
    endtask

    task automatic test_reset_mid_load();
        for (int k = 7; k >= 3; k--) begin
            cfg_valid = 1; cfg_bit = 1'b1;
            step();
        end
        cfg_valid = 0;
        rst_n = 0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midload_busy got=%b want=0", busy); end
        step();
        rst_n = 1;
        tt3 = 8'h00;
        repeat (3) begin
            step();
            checks++; if (cfg_done !== 1'b0) begin failures++; $display("FAIL midload_cfg_done got=%b want=0", cfg_done); end
        end
        $display("reset mid-load, tt back to %h", tt3);
        sweep3(-1, 0, 1'b0);
    endtask

    task automatic test_random_eval();
        bit   exp_valid = 0, exp_data = 0, iv, ordy;
        logic [2:0] exp_idx = '0, d;
        load3(8'($urandom), $urandom_range(1, 7), $urandom_range(0, 3));
        for (int i = 0; i < 60; i++) begin
            iv = 1'($urandom); d = 3'($urandom); ordy = ($urandom_range(0, 3) != 0);
            in_valid = iv; in_data = d; out_ready = ordy;
            #1;
            checks++; if (in_ready !== (!exp_valid || ordy)) begin failures++; $display("FAIL rand_in_ready got=%b want=%b", in_ready, (!exp_valid || ordy)); end
            step();
            if (iv && (!exp_valid || ordy)) begin exp_valid = 1; exp_data = tt3[d]; exp_idx = d; end
            else if (exp_valid && ordy) exp_valid = 0;
            checks++; if (out_valid !== exp_valid) begin failures++; $display("FAIL rand_valid got=%b want=%b", out_valid, exp_valid); end
            if (exp_valid) begin
                checks++; if (out_data !== exp_data || out_idx !== exp_idx) begin failures++; $display("FAIL rand_result got=%b/%0d want=%b/%0d", out_data, out_idx, exp_data, exp_idx); end
                $display("eval idx=%0d data=%b", out_idx, out_data);
            end
        end
        in_valid = 0; out_ready = 1;
        step();
        step();
    endtask

    task automatic load4(input logic [15:0] val, input int nbits);
        for (int k = 15; k >= 16 - nbits; k--) begin
            f_cfg_valid = 1; f_cfg_bit = val[k];
            step();
            f_cfg_valid = 0;
            checks++; if (f_cfg_done !== (k == 0)) begin failures++; $display("FAIL n4_cfg_done bit=%0d got=%b want=%b", 16-k, f_cfg_done, (k == 0)); end
        end
        if (nbits == 16) begin tt4 = val; $display("load4 tt=%h", val); end
    endtask

    task automatic sweep4();
        f_sweep_start = 1; f_out_ready = 1;
        step();
        f_sweep_start = 0;
        for (int e = 0; e < 16; e++) begin
            step();
            checks++; if (f_out_valid !== 1'b1 || f_out_idx !== 4'(e)) begin failures++; $display("FAIL n4_sweep_idx got=%b/%0d want=1/%0d", f_out_valid, f_out_idx, e); end
            checks++; if (f_out_data !== tt4[e]) begin failures++; $display("FAIL n4_sweep_data e=%0d got=%b want=%b", e, f_out_data, tt4[e]); end
            checks++; if (f_out_last !== (e == 15)) begin failures++; $display("FAIL n4_sweep_last e=%0d got=%b want=%b", e, f_out_last, (e == 15)); end
            $display("sweep4 idx=%0d data=%b last=%b", f_out_idx, f_out_data, f_out_last);
        end
        step();
        checks++; if (f_busy !== 1'b0 || f_out_valid !== 1'b0) begin failures++; $display("FAIL n4_sweep_end got busy=%b valid=%b want 0 0", f_busy, f_out_valid); end
    endtask

    task automatic test_n4();
        sweep4();
        load4(16'($urandom), 16);
        step();
        sweep4();
        load4(16'hFFFF, 9);
        f_rst_n = 0;
        #1;
        checks++; if (f_busy !== 1'b0) begin failures++; $display("FAIL n4_midload_busy got=%b want=0", f_busy); end
        step();
        f_rst_n = 1;
        tt4 = INIT4;
        repeat (2) begin
            step();
            checks++; if (f_cfg_done !== 1'b0) begin failures++; $display("FAIL n4_midload_done got=%b want=0", f_cfg_done); end
        end
        sweep4();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        load3(8'h44, 3, 2);
        test_eval_b2b();
        sweep3(-1, 0, 1'b0);
        sweep3(2, 3, 1'b0);
        sweep3(-1, 0, 1'b1);
        test_reset_mid_load();
        test_random_eval();
        test_n4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
